stream_repacker: RTL and testbench

- Parametrised successor to the 8-byte stream normalizer. Accepts a packetised byte stream of IN_BYTES-wide beats, each with a partial-fill count. Emits a dense stream of OUT_BYTES-wide beats; IN_BYTES and OUT_BYTES are independent, so the block widens, narrows or normalises.
- Only the last beat of a packet may be partial on the output. Each last beat also reports the total packet length. Sits between variable-fill producers (parsers, decapsulators) and fixed-width consumers.

---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_byte_shifter.sv | 35 +++
 rtl/stream_repacker.sv | 124 ++++++++++++
 tb/tb_stream_repacker.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared byte-stream types and the beat byte-count encoding, where a count of 0 means a full beat.
package stream_pkg;

    typedef logic [7:0] byte_t;

    function automatic int CNT_W(input int bytes);
        return $clog2(bytes);
    endfunction

    function automatic int cnt_to_bytes(input int cnt, input int bytes);
        return (cnt == 0) ? bytes : cnt;
    endfunction

    function automatic int bytes_to_cnt(input int n, input int bytes);
        return n % bytes;
    endfunction

endpackage

// File: rtl/stream_byte_shifter.sv
// Combinational funnel: drops `consumed_i` bytes off the bottom of the buffer and writes
// `ins_n_i` input bytes starting at `ins_pos_i`; no state, no handshake.
module stream_byte_shifter
    import stream_pkg::*;
#(
    parameter int IN_BYTES  = 8,
    parameter int BUF_BYTES = 16,
    parameter int POS_W     = 5
) (
    input  logic [8*BUF_BYTES-1:0] buf_i,
    input  logic [POS_W-1:0]       consumed_i,
    input  logic [8*IN_BYTES-1:0]  ins_data_i,
    input  logic [POS_W-1:0]       ins_pos_i,
    input  logic [POS_W-1:0]       ins_n_i,
    output logic [8*BUF_BYTES-1:0] buf_o
);

    // Inserted bytes always land at or above the surviving data, so they simply override.
    always_comb begin
        buf_o = '0;
        for (int j = 0; j < BUF_BYTES; j++) begin
            for (int k = j; k < BUF_BYTES; k++) begin
                if (int'(consumed_i) == k - j) begin
                    buf_o[8*j +: 8] = buf_i[8*k +: 8];
                end
            end
            for (int k = 0; k < IN_BYTES; k++) begin
                if ((k < int'(ins_n_i)) && (int'(ins_pos_i) == j - k)) begin
                    buf_o[8*j +: 8] = ins_data_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/stream_repacker.sv
// Repacks variable-fill IN_BYTES beats into dense OUT_BYTES beats per packet; 1-cycle min latency, all flags from state.
// Output holds stable until accepted; input stalls when the buffer cannot take a full beat or a packet is draining.
module stream_repacker
    import stream_pkg::*;
#(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 8,
    parameter int LEN_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*IN_BYTES-1:0]        in_data,
    input  logic [CNT_W(IN_BYTES)-1:0]   in_cnt,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [8*OUT_BYTES-1:0]       out_data,
    output logic [CNT_W(OUT_BYTES)-1:0]  out_cnt,
    output logic                         out_last,
    output logic [LEN_W-1:0]             out_len,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
    localparam int FILL_W    = $clog2(BUF_BYTES + 1);
    localparam int OCW       = CNT_W(OUT_BYTES);
    localparam int LSUM_W    = LEN_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [8*BUF_BYTES-1:0] buf_q, buf_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   eop_q, eop_d;
    logic [LEN_W-1:0]       len_q, len_d;

    logic                   in_fire, out_fire;
    logic [FILL_W-1:0]      in_n, ins_n, consumed, wr_pos, valid_bytes;
    logic [LSUM_W-1:0]      len_sum;

    assign in_ready  = rst_n && !eop_q && (fill_q <= FILL_W'(BUF_BYTES - IN_BYTES));
    assign out_valid = (fill_q >= FILL_W'(OUT_BYTES)) || (eop_q && (fill_q != '0));
    assign out_last  = eop_q && (fill_q != '0) && (fill_q <= FILL_W'(OUT_BYTES));
    assign out_cnt   = out_last ? OCW'(bytes_to_cnt(int'(fill_q), OUT_BYTES)) : '0;
    assign out_len   = out_last ? len_q : '0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign in_n     = FILL_W'(cnt_to_bytes(int'(in_cnt), IN_BYTES));
    assign ins_n    = in_fire ? in_n : '0;
    assign len_sum  = {1'b0, len_q} + LSUM_W'(in_n);

    // Bytes above the valid count are forced to zero so stale buffer contents never leak.
    always_comb begin
        valid_bytes = '0;
        if (out_valid) begin
            valid_bytes = out_last ? fill_q : FILL_W'(OUT_BYTES);
        end
        out_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (j < int'(valid_bytes)) begin
                out_data[8*j +: 8] = buf_q[8*j +: 8];
            end
        end
    end

    always_comb begin
        consumed = '0;
        if (out_fire) begin
            consumed = out_last ? fill_q : FILL_W'(OUT_BYTES);
        end
        wr_pos = fill_q - consumed;
        fill_d = wr_pos + ins_n;
        eop_d  = eop_q;
        len_d  = len_q;
        if (out_fire && out_last) begin
            eop_d = 1'b0;
            len_d = '0;
        end
        if (in_fire) begin
            if (in_last) begin
                eop_d = 1'b1;
            end
            len_d = len_sum[LEN_W] ? LEN_MAX : len_sum[LEN_W-1:0];
        end
    end

    stream_byte_shifter #(
        .IN_BYTES  (IN_BYTES),
        .BUF_BYTES (BUF_BYTES),
        .POS_W     (FILL_W)
    ) u_shifter (
        .buf_i      (buf_q),
        .consumed_i (consumed),
        .ins_data_i (in_data),
        .ins_pos_i  (wr_pos),
        .ins_n_i    (ins_n),
        .buf_o      (buf_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= '0;
            eop_q  <= 1'b0;
            len_q  <= '0;
        end else begin
            fill_q <= fill_d;
            eop_q  <= eop_d;
            len_q  <= len_d;
        end
    end

    // Payload needs no reset: every output byte is gated by fill.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fill_q <= FILL_W'(BUF_BYTES));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_cnt)
                                       && $stable(out_last) && $stable(out_len)));

endmodule

// File: tb/tb_stream_repacker.sv
// Bench for stream_repacker over 8/8, 8/4, 4/8 and a narrow-length 8/8 configuration.
module tb_stream_repacker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] in_data;
    logic [2:0]  in_cnt;
    logic        in_last, in_valid, out_ready;
    int          sel;
    int          checks, errors;

    logic [63:0] d0_data, d2_data, d3_data;
    logic [31:0] d1_data;
    logic [2:0]  d0_cnt, d2_cnt, d3_cnt;
    logic [1:0]  d1_cnt;
    logic [15:0] d0_len, d1_len, d2_len;
    logic [3:0]  d3_len;
    logic        d0_last, d1_last, d2_last, d3_last;
    logic        d0_valid, d1_valid, d2_valid, d3_valid;
    logic        d0_rdy, d1_rdy, d2_rdy, d3_rdy;

    logic [63:0] ob_data;
    logic [2:0]  ob_cnt;
    logic [15:0] ob_len;
    logic        ob_last, ob_valid, ob_rdy;
    logic [84:0] obs;

    stream_repacker #(.IN_BYTES(8), .OUT_BYTES(8), .LEN_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
        .in_valid(in_valid && sel == 0), .in_ready(d0_rdy), .out_data(d0_data), .out_cnt(d0_cnt),
        .out_last(d0_last), .out_len(d0_len), .out_valid(d0_valid), .out_ready(out_ready && sel == 0));

    stream_repacker #(.IN_BYTES(8), .OUT_BYTES(4), .LEN_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
        .in_valid(in_valid && sel == 1), .in_ready(d1_rdy), .out_data(d1_data), .out_cnt(d1_cnt),
        .out_last(d1_last), .out_len(d1_len), .out_valid(d1_valid), .out_ready(out_ready && sel == 1));

    stream_repacker #(.IN_BYTES(4), .OUT_BYTES(8), .LEN_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[31:0]), .in_cnt(in_cnt[1:0]), .in_last(in_last),
        .in_valid(in_valid && sel == 2), .in_ready(d2_rdy), .out_data(d2_data), .out_cnt(d2_cnt),
        .out_last(d2_last), .out_len(d2_len), .out_valid(d2_valid), .out_ready(out_ready && sel == 2));

    stream_repacker #(.IN_BYTES(8), .OUT_BYTES(8), .LEN_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
        .in_valid(in_valid && sel == 3), .in_ready(d3_rdy), .out_data(d3_data), .out_cnt(d3_cnt),
        .out_last(d3_last), .out_len(d3_len), .out_valid(d3_valid), .out_ready(out_ready && sel == 3));

    always_comb begin
        ob_data = d0_data; ob_cnt = d0_cnt; ob_last = d0_last;
        ob_len = d0_len; ob_valid = d0_valid; ob_rdy = d0_rdy;
        case (sel)
            1: begin
                ob_data = {32'h0, d1_data}; ob_cnt = {1'b0, d1_cnt}; ob_last = d1_last;
                ob_len = d1_len; ob_valid = d1_valid; ob_rdy = d1_rdy;
            end
            2: begin
                ob_data = d2_data; ob_cnt = d2_cnt; ob_last = d2_last;
                ob_len = d2_len; ob_valid = d2_valid; ob_rdy = d2_rdy;
            end
            3: begin
                ob_data = d3_data; ob_cnt = d3_cnt; ob_last = d3_last;
                ob_len = {12'h0, d3_len}; ob_valid = d3_valid; ob_rdy = d3_rdy;
            end
            default: ;
        endcase
    end

    assign obs = {ob_valid, ob_last, ob_cnt, ob_len, ob_data};

    function automatic logic [84:0] beat(input logic v, input logic l, input logic [2:0] c,
                                         input logic [15:0] len, input logic [63:0] d);
        return {v, l, c, len, d};
    endfunction

    function automatic int cfg_in(input int s);   return (s == 2) ? 4 : 8;      endfunction
    function automatic int cfg_out(input int s);  return (s == 1) ? 4 : 8;      endfunction
    function automatic int cfg_lmax(input int s); return (s == 3) ? 15 : 65535; endfunction

    task automatic do_reset(input int s);
        sel = s; rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_cnt = 3'd0; in_data = 64'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_cnt = 3'd0; in_data = '1; in_last = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            checks++;
            if (ob_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_low s=%0d got %b want 0", s, ob_rdy); end
        end
        in_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            checks++;
            if (obs !== beat(0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_out s=%0d got %h want 0", s, obs); end
            checks++;
            if (ob_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy s=%0d got %b want 1", s, ob_rdy); end
        end
    endtask

    task automatic test_partial_fill();
        do_reset(0); out_ready = 1'b1;
        in_data = 64'h0123456789abcdef; in_cnt = 3'd4; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_last = 1'b1; #1;
        checks++;
        if (obs !== beat(0, 0, 0, 0, 0) || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL partial_mid got %h rdy %b want 0 rdy 1", obs, ob_rdy);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; #1;
        checks++;
        if (obs !== beat(1, 1, 0, 8, 64'h89abcdef89abcdef)) begin
            errors++; $display("FAIL partial_out got %h want %h", obs, beat(1, 1, 0, 8, 64'h89abcdef89abcdef));
        end
        @(negedge clk); #1;
        checks++;
        if (ob_valid !== 1'b0 || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL partial_end got v=%b rdy=%b want v=0 rdy=1", ob_valid, ob_rdy);
        end
    endtask

    task automatic test_narrow();
        do_reset(1); out_ready = 1'b1;
        in_data = 64'h0123456789abcdef; in_cnt = 3'd0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; #1;
        checks++;
        if (obs !== beat(1, 0, 0, 0, 64'h89abcdef) || ob_rdy !== 1'b0) begin
            errors++; $display("FAIL narrow_b0 got %h rdy %b want %h rdy 0", obs, ob_rdy, beat(1, 0, 0, 0, 64'h89abcdef));
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== beat(1, 1, 0, 8, 64'h01234567) || ob_rdy !== 1'b0) begin
            errors++; $display("FAIL narrow_b1 got %h rdy %b want %h rdy 0", obs, ob_rdy, beat(1, 1, 0, 8, 64'h01234567));
        end
        @(negedge clk); #1;
        checks++;
        if (ob_valid !== 1'b0 || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL narrow_end got v=%b rdy=%b want v=0 rdy=1", ob_valid, ob_rdy);
        end
    endtask

    task automatic test_widen();
        do_reset(2); out_ready = 1'b1;
        in_data = 64'h03020100; in_cnt = 3'd0; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_data = 64'h07060504;
        @(negedge clk);
        in_data = 64'h0b0a0908; in_cnt = 3'd2; in_last = 1'b1; #1;
        checks++;
        if (obs !== beat(1, 0, 0, 0, 64'h0706050403020100) || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL widen_b0 got %h rdy %b want %h rdy 1", obs, ob_rdy, beat(1, 0, 0, 0, 64'h0706050403020100));
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_cnt = 3'd0; #1;
        checks++;
        if (obs !== beat(1, 1, 2, 10, 64'h0908)) begin
            errors++; $display("FAIL widen_b1 got %h want %h", obs, beat(1, 1, 2, 10, 64'h0908));
        end
        @(negedge clk); #1;
        checks++;
        if (ob_valid !== 1'b0) begin errors++; $display("FAIL widen_end got v=%b want 0", ob_valid); end
    endtask

    task automatic test_backpressure();
        do_reset(0); out_ready = 1'b0;
        in_data = 64'h0123456789abcdef; in_cnt = 3'd7; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_last = 1'b1; #1;
        checks++;
        if (ob_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy7 got %b want 1", ob_rdy); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs !== beat(1, 0, 0, 0, 64'hef23456789abcdef) || ob_rdy !== 1'b0) begin
                errors++; $display("FAIL bp_hold k=%0d got %h rdy %b want %h rdy 0", k, obs, ob_rdy, beat(1, 0, 0, 0, 64'hef23456789abcdef));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== beat(1, 1, 6, 14, 64'h000023456789abcd)) begin
            errors++; $display("FAIL bp_tail got %h want %h", obs, beat(1, 1, 6, 14, 64'h000023456789abcd));
        end
        @(negedge clk); #1;
        checks++;
        if (ob_valid !== 1'b0 || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_end got v=%b rdy=%b want v=0 rdy=1", ob_valid, ob_rdy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(0); out_ready = 1'b1;
        in_data = 64'h1111111111111111; in_cnt = 3'd0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_last = (k == 3); #1;
            checks++;
            if (ob_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy k=%0d got %b want 1", k, ob_rdy); end
            if (k > 0) begin
                checks++;
                if (obs !== beat(1, 0, 0, 0, 64'h1111111111111111)) begin
                    errors++; $display("FAIL b2b_out k=%0d got %h want %h", k, obs, beat(1, 0, 0, 0, 64'h1111111111111111));
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; #1;
        checks++;
        if (obs !== beat(1, 1, 0, 32, 64'h1111111111111111) || ob_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b_last got %h rdy %b want %h rdy 0", obs, ob_rdy, beat(1, 1, 0, 32, 64'h1111111111111111));
        end
        @(negedge clk); #1;
        checks++;
        if (ob_valid !== 1'b0 || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL b2b_end got v=%b rdy=%b want v=0 rdy=1", ob_valid, ob_rdy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(0); out_ready = 1'b1;
        in_data = 64'h0000000000aabbcc; in_cnt = 3'd3; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0; #1;
        checks++;
        if (ob_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy got %b want 0", ob_rdy); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++;
        if (obs !== beat(0, 0, 0, 0, 0) || ob_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_rst_state got %h rdy %b want 0 rdy 1", obs, ob_rdy);
        end
        in_data = 64'h0123456789abcdef; in_cnt = 3'd0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; #1;
        checks++;
        if (obs !== beat(1, 1, 0, 8, 64'h0123456789abcdef)) begin
            errors++; $display("FAIL mid_rst_pkt got %h want %h", obs, beat(1, 1, 0, 8, 64'h0123456789abcdef));
        end
        @(negedge clk);
    endtask

    // Packets are generated as byte lists; expected beats are those lists cut into OUT-byte chunks.
    task automatic test_random(input int s, input int npkt, input int rdy_pct);
        logic [63:0] bd[$];
        int          bn[$];
        bit          bl[$];
        logic [84:0] ex[$];
        logic [7:0]  pb[$];
        logic [84:0] held;
        logic [63:0] d;
        bit          hold, lst;
        int          in_w, out_w, lmax, len, pos, n, ib, oe, cyc;
        in_w = cfg_in(s); out_w = cfg_out(s); lmax = cfg_lmax(s);
        for (int p = 0; p < npkt; p++) begin
            len = $urandom_range(1, 40);
            pb.delete();
            for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
            pos = 0;
            while (pos < len) begin
                n = $urandom_range(1, in_w);
                if (n > len - pos) n = len - pos;
                d = {$urandom, $urandom};
                for (int i = 0; i < n; i++) begin
                    d = (d & ~(64'hff << (8 * i))) | (64'(pb[pos + i]) << (8 * i));
                end
                bd.push_back(d); bn.push_back(n); bl.push_back(pos + n == len);
                pos += n;
            end
            pos = 0;
            while (pos < len) begin
                n = (len - pos > out_w) ? out_w : len - pos;
                lst = (pos + n == len);
                d = 64'h0;
                for (int i = 0; i < n; i++) d = d | (64'(pb[pos + i]) << (8 * i));
                ex.push_back(beat(1'b1, lst, lst ? 3'(n % out_w) : 3'd0,
                                  lst ? 16'((len > lmax) ? lmax : len) : 16'd0, d));
                pos += n;
            end
        end
        do_reset(s);
        ib = 0; oe = 0; cyc = 0; hold = 1'b0; held = '0;
        while (oe < ex.size() && cyc < 8000) begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (ib < bd.size() && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = bd[ib]; in_cnt = 3'(bn[ib] % in_w); in_last = bl[ib];
            end else begin
                in_valid = 1'b0; in_data = {$urandom, $urandom}; in_cnt = 3'($urandom); in_last = 1'($urandom);
            end
            #1;
            if (hold) begin
                checks++;
                if (obs !== held) begin errors++; $display("FAIL rand_hold s=%0d got %h want %h", s, obs, held); end
            end
            if (in_valid && ob_rdy) ib++;
            if (ob_valid && out_ready) begin
                checks++;
                if (obs !== ex[oe]) begin
                    errors++; $display("FAIL rand_beat s=%0d idx=%0d got %h want %h", s, oe, obs, ex[oe]);
                end
                oe++;
            end
            hold = ob_valid && !out_ready;
            held = obs;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; #1;
        checks++;
        if (oe != ex.size() || ib != bd.size() || ob_valid !== 1'b0) begin
            errors++; $display("FAIL rand_done s=%0d got out %0d in %0d v=%b want out %0d in %0d v=0",
                               s, oe, ib, ob_valid, ex.size(), bd.size(), ob_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0; rst_n = 1'b0;
        in_data = 64'h0; in_cnt = 3'd0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_partial_fill();
        test_narrow();
        test_widen();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random(0, 30, 75);
        test_random(1, 30, 60);
        test_random(2, 30, 80);
        test_random(3, 30, 50);
        test_random(0, 20, 100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
